// File: rtl/decoder_scan.sv
// N-to-2^N one-hot decoder with registered outputs, manual select and a
// prescaled scan mode that walks the active line through every output.
module decoder_scan #(
    parameter int N       = 2,
    parameter int PRESC   = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       sel,
    input  logic               load,
    output logic [(1<<N)-1:0]  y,
    output logic [N-1:0]       idx,
    output logic               wrap
);

    localparam int LINES = 1 << N;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]    P_LAST   = PW'(PRESC - 1);
    localparam logic [LINES-1:0] INACTIVE = {LINES{ACT_LOW}};

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       idx_reg, idx_next;
    logic [PW-1:0]      presc_reg, presc_next;
    logic [LINES-1:0]   y_reg, y_next;
    logic               wrap_reg, wrap_next;
    logic [LINES-1:0]   one_hot;

    // Decode the index that will be registered this edge, so y and idx stay aligned.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_decode
            assign one_hot[gi] = (idx_next == N'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        presc_next = presc_reg;
        wrap_next  = 1'b0;
        y_next     = INACTIVE;

        if (!en)
            state_next = IDLE;
        else if (!mode)
            state_next = MANUAL;
        else
            state_next = SCAN;

        case (state_next)
            MANUAL: begin
                idx_next   = sel;
                presc_next = '0;
            end
            SCAN: begin
                if (load) begin
                    idx_next   = sel;
                    presc_next = '0;
                end else if (state_reg == SCAN) begin
                    // The first cycle after entering SCAN only re-displays the held position.
                    if (presc_reg == P_LAST) begin
                        presc_next = '0;
                        idx_next   = idx_reg + N'(1);
                        wrap_next  = (idx_reg == {N{1'b1}});
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
            end
            default: ;
        endcase

        if (state_next != IDLE)
            y_next = one_hot ^ INACTIVE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            presc_reg <= '0;
            y_reg     <= INACTIVE;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            presc_reg <= presc_next;
            y_reg     <= y_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign y    = y_reg;
    assign idx  = idx_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan.sv
// Two decoder_scan instances (N=2/PRESC=3/active-high and N=3/PRESC=1/active-low)
// driven by shared control inputs and compared each cycle to a behavioural model.
module tb_decoder_scan;

    logic       clk;
    logic       rst_n, en, mode, load;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    decoder_scan #(.N(2), .PRESC(3), .ACT_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a), .load(load),
        .y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan #(.N(3), .PRESC(1), .ACT_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b), .load(load),
        .y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per instance, which mode it is in, the displayed position, and
    // how many cycles that position has already been shown.
    int lines_c[2] = '{4, 8};
    int presc_c[2] = '{3, 1};
    int al_c[2]    = '{0, 1};
    int m_scan[2];
    int m_idx[2];
    int m_p[2];
    int m_wrap[2];
    int m_act[2];
    int exp_y[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input int s);
        int mask;
        if (!rst_n) begin
            m_scan[k] = 0; m_idx[k] = 0; m_p[k] = 0; m_wrap[k] = 0; m_act[k] = 0;
        end else if (!en) begin
            m_scan[k] = 0; m_wrap[k] = 0; m_act[k] = 0;
        end else if (!mode) begin
            m_scan[k] = 0; m_idx[k] = s; m_p[k] = 0; m_wrap[k] = 0; m_act[k] = 1;
        end else begin
            m_act[k]  = 1;
            m_wrap[k] = 0;
            if (load) begin
                m_idx[k] = s;
                m_p[k]   = 0;
            end else if (m_scan[k] == 1) begin
                if (m_p[k] + 1 == presc_c[k]) begin
                    m_p[k] = 0;
                    if (m_idx[k] == lines_c[k] - 1) m_wrap[k] = 1;
                    m_idx[k] = (m_idx[k] + 1) % lines_c[k];
                end else begin
                    m_p[k]++;
                end
            end
            m_scan[k] = 1;
        end
        mask     = (1 << lines_c[k]) - 1;
        exp_y[k] = m_act[k] ? (1 << m_idx[k]) : 0;
        if (al_c[k] != 0) exp_y[k] = exp_y[k] ^ mask;
    endtask

    task automatic step();
        model_step(0, int'(sel_a));
        model_step(1, int'(sel_b));
        @(posedge clk);
        #2;
        check("a_y", 32'(y_a), exp_y[0]);
        check("a_idx", 32'(idx_a), m_idx[0]);
        check("a_wrap", 32'(wrap_a), m_wrap[0]);
        check("a_active_cnt", $countones(y_a), m_act[0]);
        check("b_y", 32'(y_b), exp_y[1]);
        check("b_idx", 32'(idx_b), m_idx[1]);
        check("b_wrap", 32'(wrap_b), m_wrap[1]);
        check("b_active_cnt", $countones(~y_b), m_act[1]);
    endtask

    // Advance until instance A shows position i with prescale count p (bounded).
    task automatic run_until(input int i, input int p);
        int reached = 0;
        for (int c = 0; c < 50; c++) begin
            if (m_idx[0] == i && m_p[0] == p) begin
                reached = 1;
                break;
            end
            sel_b = 3'($urandom);
            step();
        end
        check("wait_bound", reached, 1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0;
        sel_a = 2'd0; sel_b = 3'd0;

        // Reset dominates an enabled scan request.
        step();
        step();
        check("rst_y_a", 32'(y_a), 32'h0);
        check("rst_y_b", 32'(y_b), 32'hFF);

        // Manual decode, one cycle latency.
        rst_n = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            sel_b = 3'(s + 4);
            step();
            check("man_y", 32'(y_a), 32'(1 << s));
            check("man_idx", 32'(idx_a), 32'(s));
        end
        load = 1'b1;
        step();
        check("man_load_ignored", 32'(idx_a), 32'd3);
        load = 1'b0;

        // Scan from reset: 3 cycles per line, wrap on the first cycle of the second 0001.
        rst_n = 1'b0; mode = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            check("scan_y", 32'(y_a), 32'(1 << ((k / 3) % 4)));
            check("scan_wrap", 32'(wrap_a), 32'(k == 12));
            check("scan_b_y", 32'(y_b), 32'(8'hFF ^ (8'h1 << (k % 8))));
        end

        // Load mid-prescale jumps to line 3 for a full period, then wraps.
        run_until(1, 1);
        load = 1'b1; sel_a = 2'd3;
        step();
        load = 1'b0;
        check("load_y", 32'(y_a), 32'h8);
        step();
        step();
        check("load_hold_y", 32'(y_a), 32'h8);
        step();
        check("load_wrap_y", 32'(y_a), 32'h1);
        check("load_wrap", 32'(wrap_a), 32'd1);

        // Load at the terminal count of line 3 suppresses the wrap.
        run_until(3, 2);
        load = 1'b1; sel_a = 2'd0;
        step();
        load = 1'b0;
        check("tc_load_y", 32'(y_a), 32'h1);
        check("tc_load_wrap", 32'(wrap_a), 32'd0);

        // Enable gap mid-scan: all inactive, then resume at the held position.
        run_until(2, 1);
        en = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            check("gap_y_a", 32'(y_a), 32'h0);
            check("gap_y_b", 32'(y_b), 32'hFF);
        end
        en = 1'b1;
        step();
        check("resume_idx", 32'(idx_a), 32'd2);
        step();
        check("resume_hold", 32'(idx_a), 32'd2);
        step();
        check("resume_step", 32'(idx_a), 32'd3);

        // Reset asserted between edges has no effect until the next edge.
        rst_n = 1'b0;
        #3;
        check("async_rst_hold_a", 32'(y_a), exp_y[0]);
        check("async_rst_hold_b", 32'(y_b), exp_y[1]);
        step();
        check("rst_again_y", 32'(y_a), 32'h0);
        rst_n = 1'b1;

        // Randomized phase.
        for (int r = 0; r < 500; r++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            en    = ($urandom_range(0, 99) >= 10);
            mode  = ($urandom_range(0, 99) >= 15);
            load  = ($urandom_range(0, 99) < 6);
            sel_a = 2'($urandom);
            sel_b = 3'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
